// File: rtl/hazard_scoreboard_pkg.sv
// rtl/hazard_scoreboard_pkg.sv - opcode and producer-latency constants shared by the hazard scoreboard and forwarding unit
package hazard_scoreboard_pkg;

    localparam logic [6:0] ARITHMETIC     = 7'b0110011;
    localparam logic [6:0] ARITHMETIC_IMM = 7'b0010011;
    localparam logic [6:0] LOAD           = 7'b0000011;
    localparam logic [6:0] STORE          = 7'b0100011;
    localparam logic [6:0] BRANCH         = 7'b1100011;
    localparam logic [6:0] JAL            = 7'b1101111;
    localparam logic [6:0] JALR           = 7'b1100111;
    localparam logic [6:0] LUI            = 7'b0110111;
    localparam logic [6:0] AUIPC          = 7'b0010111;

    localparam int LAT_ALU  = 0;
    localparam int LAT_LOAD = 1;
    localparam int LAT_MUL  = 3;
    localparam int LAT_DIV  = 7;

endpackage

// File: rtl/hazard_use_decode.sv
// rtl/hazard_use_decode.sv - which register operands an opcode reads and writes (x0 never counts)
module hazard_use_decode
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [6:0]            opcode,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    input  logic [REG_ADDR_W-1:0] rd,
    output logic                  use_rs1,
    output logic                  use_rs2,
    output logic                  writes_rd
);

    always_comb begin
        use_rs1   = (opcode inside {ARITHMETIC, ARITHMETIC_IMM, LOAD, STORE, BRANCH, JALR})
                    && (rs1 != '0);
        use_rs2   = (opcode inside {ARITHMETIC, STORE, BRANCH}) && (rs2 != '0);
        writes_rd = (opcode inside {ARITHMETIC, ARITHMETIC_IMM, LOAD, JAL, JALR, LUI, AUIPC})
                    && (rd != '0);
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - per-register countdown scoreboard raising RAW/WAW stalls for the ID stage
// HAZARD_PERF_EN adds the saturating stall_cnt output.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NUM_REGS   = 32,
    parameter int REG_ADDR_W = 5,
    parameter int LAT_W      = 3,
    parameter int MAX_LAT    = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  issue_valid,
    input  logic [6:0]            opcode,
    input  logic [REG_ADDR_W-1:0] rs1_ID,
    input  logic [REG_ADDR_W-1:0] rs2_ID,
    input  logic [REG_ADDR_W-1:0] rd_ID,
    input  logic [LAT_W-1:0]      lat_ID,
    input  logic                  pipe_hold,
    output logic                  pc_write,
    output logic                  IF_ID_write,
    output logic                  control_op,
    output logic                  hazard_rs1,
    output logic                  hazard_rs2,
    output logic                  hazard_waw
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]           stall_cnt
`endif
);

    // Sized to the full index space so any rs/rd lookup stays in range; untracked slots stay 0.
    localparam int ENTRIES = 1 << REG_ADDR_W;

    logic [LAT_W-1:0] cnt_q [ENTRIES];
    logic [LAT_W-1:0] cnt_d [ENTRIES];
    logic             use_rs1, use_rs2, writes_rd;
    logic             hazard, issue_fire;

    hazard_use_decode #(.REG_ADDR_W(REG_ADDR_W)) u_decode (
        .opcode    (opcode),
        .rs1       (rs1_ID),
        .rs2       (rs2_ID),
        .rd        (rd_ID),
        .use_rs1   (use_rs1),
        .use_rs2   (use_rs2),
        .writes_rd (writes_rd)
    );

    always_comb begin
        hazard_rs1  = issue_valid && use_rs1 && (cnt_q[rs1_ID] != '0);
        hazard_rs2  = issue_valid && use_rs2 && (cnt_q[rs2_ID] != '0);
        hazard_waw  = issue_valid && writes_rd && (cnt_q[rd_ID] > lat_ID);
        hazard      = hazard_rs1 || hazard_rs2 || hazard_waw;
        pc_write    = !hazard;
        IF_ID_write = !hazard;
        control_op  = hazard;
        issue_fire  = issue_valid && !hazard && !pipe_hold && writes_rd;
    end

    // A fresh issue overrides the countdown of its destination in the same cycle.
    always_comb begin
        for (int r = 0; r < ENTRIES; r++) begin
            cnt_d[r] = cnt_q[r];
        end
        if (!pipe_hold) begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (issue_fire && (rd_ID == REG_ADDR_W'(r))) begin
                    cnt_d[r] = lat_ID;
                end else if (cnt_q[r] != '0) begin
                    cnt_d[r] = cnt_q[r] - LAT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < ENTRIES; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < ENTRIES; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && issue_fire) begin
            assert ({{(32-LAT_W){1'b0}}, lat_ID} <= MAX_LAT);
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hazard && !pipe_hold && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed and random stimulus against a ready-time reference model
module tb_hazard_scoreboard;

    localparam logic [6:0] O_ARITH = 7'b0110011;
    localparam logic [6:0] O_ARIMM = 7'b0010011;
    localparam logic [6:0] O_LOAD  = 7'b0000011;
    localparam logic [6:0] O_STORE = 7'b0100011;
    localparam logic [6:0] O_BRAN  = 7'b1100011;
    localparam logic [6:0] O_JAL   = 7'b1101111;
    localparam logic [6:0] O_JALR  = 7'b1100111;
    localparam logic [6:0] O_LUI   = 7'b0110111;
    localparam logic [6:0] O_AUIPC = 7'b0010111;
    localparam logic [6:0] O_BAD   = 7'b1111111;

    logic        clk = 1'b0;
    logic        reset, issue_valid, pipe_hold;
    logic [6:0]  opcode;
    logic [4:0]  rs1_ID, rs2_ID, rd_ID;
    logic [2:0]  lat_ID;
    logic        pc_write, IF_ID_write, control_op;
    logic        hazard_rs1, hazard_rs2, hazard_waw;
    logic [31:0] stall_cnt;

    int          n_cmp = 0;
    int          n_bad = 0;

    // Model: ready_at[r] is the count of unheld cycles after which r's result is forwardable.
    int          ready_at [32];
    int          active;
    logic [31:0] m_stall;
    logic        last_ctrl;
    logic [6:0]  ops [10];

    hazard_scoreboard dut (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .opcode      (opcode),
        .rs1_ID      (rs1_ID),
        .rs2_ID      (rs2_ID),
        .rd_ID       (rd_ID),
        .lat_ID      (lat_ID),
        .pipe_hold   (pipe_hold),
        .pc_write    (pc_write),
        .IF_ID_write (IF_ID_write),
        .control_op  (control_op),
        .hazard_rs1  (hazard_rs1),
        .hazard_rs2  (hazard_rs2),
        .hazard_waw  (hazard_waw)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rem(input logic [4:0] x);
        if (x == 5'd0) return 0;
        return (ready_at[x] > active) ? ready_at[x] - active : 0;
    endfunction

    task automatic step(input logic v, input logic [6:0] op, input logic [4:0] a,
                        input logic [4:0] b, input logic [4:0] d, input logic [2:0] l,
                        input logic h, input logic r);
        logic u1, u2, wr, e1, e2, ew, eh;
        @(negedge clk);
        issue_valid = v; opcode = op; rs1_ID = a; rs2_ID = b; rd_ID = d;
        lat_ID = l; pipe_hold = h; reset = r;
        #1;
        u1 = (op inside {O_ARITH, O_ARIMM, O_LOAD, O_STORE, O_BRAN, O_JALR}) && (a != 0);
        u2 = (op inside {O_ARITH, O_STORE, O_BRAN}) && (b != 0);
        wr = (op inside {O_ARITH, O_ARIMM, O_LOAD, O_JAL, O_JALR, O_LUI, O_AUIPC}) && (d != 0);
        e1 = v && u1 && (rem(a) > 0);
        e2 = v && u2 && (rem(b) > 0);
        ew = v && wr && (rem(d) > int'(l));
        eh = e1 || e2 || ew;
        chk("pc_write", pc_write, !eh);
        chk("if_id_write", IF_ID_write, !eh);
        chk("control_op", control_op, eh);
        chk("hazard_rs1", hazard_rs1, e1);
        chk("hazard_rs2", hazard_rs2, e2);
        chk("hazard_waw", hazard_waw, ew);
`ifdef HAZARD_PERF_EN
        chk("stall_cnt", stall_cnt, m_stall);
`endif
        last_ctrl = control_op;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 32; i++) ready_at[i] = active;
            m_stall = '0;
        end else begin
            if (eh && !h && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
            if (!h) begin
                active++;
                if (v && !eh && wr) ready_at[d] = active + int'(l);
            end
        end
    endtask

    task automatic idle(input logic h);
        step(1'b0, O_BAD, 5'd0, 5'd0, 5'd0, 3'd0, h, 1'b0);
    endtask

    // Presents one instruction until it issues; returns the stall count (99 on timeout).
    task automatic consume(input logic [6:0] op, input logic [4:0] a, input logic [4:0] b,
                           input logic [4:0] d, input logic [2:0] l, output int stalls);
        stalls = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, op, a, b, d, l, 1'b0, 1'b0);
            if (!last_ctrl) return;
            stalls++;
        end
        stalls = 99;
    endtask

    initial begin
        int s;
        ops = '{O_ARITH, O_ARIMM, O_LOAD, O_STORE, O_BRAN, O_JAL, O_JALR, O_LUI, O_AUIPC, O_BAD};
        for (int i = 0; i < 32; i++) ready_at[i] = 0;
        active = 0; m_stall = '0; last_ctrl = 1'b0;
        reset = 1'b1; issue_valid = 1'b0; opcode = O_BAD; rs1_ID = '0; rs2_ID = '0;
        rd_ID = '0; lat_ID = '0; pipe_hold = 1'b0;
        repeat (2) @(posedge clk);
        step(1'b0, O_BAD, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 1'b1);
        idle(1'b0);

        // load-use: one bubble
        step(1'b1, O_LOAD, 5'd1, 5'd0, 5'd5, 3'd1, 1'b0, 1'b0);
        consume(O_ARITH, 5'd5, 5'd1, 5'd6, 3'd0, s);
        chk("load_use_stalls", s, 1);

        // multiply feeding store data
        step(1'b1, O_ARITH, 5'd1, 5'd2, 5'd7, 3'd3, 1'b0, 1'b0);
        consume(O_STORE, 5'd2, 5'd7, 5'd0, 3'd0, s);
        chk("mul_store_stalls", s, 3);

        // WAW: ADDI waits until the multiply's countdown drops to its own latency
        step(1'b1, O_ARITH, 5'd1, 5'd2, 5'd8, 3'd3, 1'b0, 1'b0);
        consume(O_ARIMM, 5'd1, 5'd0, 5'd8, 3'd0, s);
        chk("waw_stalls", s, 3);

        // hold freezes the countdown
        step(1'b1, O_ARITH, 5'd1, 5'd2, 5'd9, 3'd3, 1'b0, 1'b0);
        idle(1'b0);
        repeat (4) idle(1'b1);
        consume(O_ARITH, 5'd9, 5'd0, 5'd11, 3'd0, s);
        chk("hold_stalls", s, 2);

        // x0 is never tracked
        step(1'b1, O_ARITH, 5'd1, 5'd2, 5'd0, 3'd7, 1'b0, 1'b0);
        consume(O_ARITH, 5'd0, 5'd0, 5'd12, 3'd0, s);
        chk("x0_stalls", s, 0);

        // reset in the middle of a stall
        step(1'b1, O_ARITH, 5'd1, 5'd2, 5'd10, 3'd3, 1'b0, 1'b0);
        step(1'b1, O_ARITH, 5'd10, 5'd0, 5'd13, 3'd0, 1'b0, 1'b0);
        chk("pre_reset_stall", last_ctrl, 1'b1);
        step(1'b1, O_ARITH, 5'd10, 5'd0, 5'd13, 3'd0, 1'b0, 1'b1);
        step(1'b1, O_ARITH, 5'd10, 5'd0, 5'd13, 3'd0, 1'b0, 1'b0);
        chk("reset_release", last_ctrl, 1'b0);

        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 9) < 8, ops[$urandom_range(0, 9)],
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 $urandom_range(0, 9) < 2, $urandom_range(0, 99) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
